// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer state encodings, instruction field positions and helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int         CPU_DW     = 16;
  localparam int         CPU_RSW    = 3;
  localparam logic [2:0] CPU_PC_SEL = 3'b111;

  // Opcodes; 4'hA..4'hE are undefined
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LDW  = 4'h6;
  localparam logic [3:0] OP_STW  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_JR   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MWAIT  = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Instruction field positions; imm6 overlaps rs2
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  function automatic logic [CPU_DW-1:0] sext6(input logic [5:0] v);
    return {{(CPU_DW-6){v[5]}}, v};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op inside {[4'hA:4'hE]};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: register-register and register-immediate arithmetic/logic for ADD..XOR and ADDI.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the inputs.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result
);

  // Select the operation; everything wraps modulo 2^DW and no flags are produced
  always_comb begin
    result = '0;
    case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB:          result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute sequencer mastering the register file and memory port.
// Latency: 4 cycles minimum per instruction (FETCH, FWAIT, DECODE, EXEC); LDW/STW add MWAIT, LDW adds WB.
// Backpressure: each memory request is held with stable address/data until mem_ack; the FSM stalls meanwhile.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int             DW     = CPU_DW,
  parameter int             RSW    = CPU_RSW,
  parameter logic [RSW-1:0] PC_SEL = CPU_PC_SEL
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DW-1:0]  regr0,
  input  logic [DW-1:0]  regr1,
  output logic [RSW-1:0] regr0s,
  output logic [RSW-1:0] regr1s,
  output logic [RSW-1:0] regws,
  output logic [DW-1:0]  regw,
  output logic           we,
  output logic           incr_pc,
  output logic [DW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic           mem_req,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  output logic           halted,
  output logic           illegal
);

  state_t         state, state_nxt;
  logic [DW-1:0]  ir, mdr;
  logic [3:0]     op;
  logic [RSW-1:0] rd, rs1, rs2;
  logic [DW-1:0]  imm, alu_b, alu_y;
  logic           is_mem;

  assign op     = ir[OP_HI:OP_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rs1    = ir[RS1_HI:RS1_LO];
  assign rs2    = ir[RS2_HI:RS2_LO];
  assign imm    = sext6(ir[IMM_HI:IMM_LO]);
  assign is_mem = (op == OP_LDW) || (op == OP_STW);
  assign alu_b  = (op == OP_ADDI) ? imm : regr1;

  cpu_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (regr0),
    .b      (alu_b),
    .result (alu_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; memory waits stall until mem_ack is sampled
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_FWAIT;
      S_FWAIT:  if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_illegal(op))     state_nxt = S_FETCH;
        else if (op == OP_HALT) state_nxt = S_HALT;
        else                    state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = is_mem ? S_MWAIT : S_FETCH;
      S_MWAIT:  if (mem_ack) state_nxt = (op == OP_LDW) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Output logic, register selects: depend only on state and IR, never on read data
  always_comb begin
    regr0s = '0;
    regr1s = '0;
    regws  = '0;
    case (state)
      S_FETCH: regr0s = PC_SEL;
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            regr0s = rs1;
            regr1s = rs2;
            regws  = rd;
          end
          OP_BZ: begin
            regr0s = rs1;
            regr1s = PC_SEL;
            regws  = PC_SEL;
          end
          OP_JR: begin
            regr0s = rs1;
            regws  = PC_SEL;
          end
          OP_LDW, OP_STW: begin
            regr0s = rs1;
            regr1s = rd;
          end
          default: ;
        endcase
      end
      S_WB:    regws = rd;
      default: ;
    endcase
  end

  // Output logic, write data and strobes; reset forces every strobe low
  always_comb begin
    regw    = '0;
    we      = 1'b0;
    incr_pc = 1'b0;
    illegal = 1'b0;
    case (state)
      S_DECODE: begin
        incr_pc = 1'b1;
        illegal = is_illegal(op);
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
            regw = alu_y;
            we   = (rd != '0);
          end
          OP_BZ: begin
            regw = regr1 + (imm << 1);
            we   = (regr0 == '0);
          end
          OP_JR: begin
            regw = regr0;
            we   = 1'b1;
          end
          default: ;
        endcase
      end
      S_WB: begin
        regw = mdr;
        we   = (rd != '0);
      end
      default: ;
    endcase
    if (reset) begin
      we      = 1'b0;
      incr_pc = 1'b0;
      illegal = 1'b0;
    end
  end

  // Memory port, IR/MDR capture and sticky halt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          mem_addr <= regr0;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
        end
        S_FWAIT: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          if (op == OP_HALT) halted <= 1'b1;
        end
        S_EXEC: begin
          if (is_mem) begin
            mem_addr  <= regr0 + imm;
            mem_wdata <= regr1;
            mem_we    <= (op == OP_STW);
            mem_req   <= 1'b1;
          end
        end
        S_MWAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mdr     <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
